// File: rtl/nrs_conj_mult_buf.sv
// NB-IoT NRS conjugate multiplier with a 4-entry product buffer.
// Registered read port feeds the downstream channel averaging stage.
module nrs_conj_mult_buf #(
  parameter int WIDTH_R_I = 16,
  parameter int NRS_MAG   = 1448,
  parameter int FRAC_BITS = 11,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [1:0]                  wr_addr,
  input  logic [1:0]                  rd_addr,
  input  logic signed [WIDTH_R_I-1:0] rx_r,
  input  logic signed [WIDTH_R_I-1:0] rx_i,
  input  logic                        nrs_r,
  input  logic                        nrs_i,
  output logic signed [WIDTH_R_I-1:0] real_part,
  output logic signed [WIDTH_R_I-1:0] imag_part
);

  localparam int FW = 2 * WIDTH_R_I + 1;
  localparam int EW = FW - WIDTH_R_I;

  localparam logic signed [FW-1:0] MAG  = FW'(NRS_MAG);
  localparam logic signed [FW-1:0] MAXV =
    FW'(2 ** (WIDTH_R_I - 1) - 1);
  localparam logic signed [FW-1:0] MINV = -MAXV - 1;

  logic signed [FW-1:0] xr, xi;
  logic signed [FW-1:0] pr, pi;
  logic signed [FW-1:0] r_nr, i_ni, i_nr, r_ni;
  logic signed [FW-1:0] re_full, im_full;
  logic signed [FW-1:0] re_sh, im_sh;

  logic signed [WIDTH_R_I-1:0] re_d, im_d;
  logic signed [WIDTH_R_I-1:0] real_d, imag_d;
  logic signed [WIDTH_R_I-1:0] real_q, imag_q;

  logic signed [WIDTH_R_I-1:0] mem_re_q [DEPTH];
  logic signed [WIDTH_R_I-1:0] mem_im_q [DEPTH];

  function automatic logic signed [WIDTH_R_I-1:0] sat(
    input logic signed [FW-1:0] v
  );
    if (v > MAXV) return MAXV[WIDTH_R_I-1:0];
    if (v < MINV) return MINV[WIDTH_R_I-1:0];
    return v[WIDTH_R_I-1:0];
  endfunction

  assign xr = {{EW{rx_r[WIDTH_R_I-1]}}, rx_r};
  assign xi = {{EW{rx_i[WIDTH_R_I-1]}}, rx_i};

  // Magnitude is a constant; sign bits only select add or subtract.
  assign pr = xr * MAG;
  assign pi = xi * MAG;

  assign r_nr = nrs_r ? -pr : pr;
  assign i_ni = nrs_i ? -pi : pi;
  assign i_nr = nrs_r ? -pi : pi;
  assign r_ni = nrs_i ? -pr : pr;

  assign re_full = r_nr + i_ni;
  assign im_full = i_nr - r_ni;

  assign re_sh = re_full >>> FRAC_BITS;
  assign im_sh = im_full >>> FRAC_BITS;

  assign re_d = sat(re_sh);
  assign im_d = sat(im_sh);

  always_comb begin
    real_d = '0;
    imag_d = '0;
    if (en) begin
      real_d = mem_re_q[rd_addr];
      imag_d = mem_im_q[rd_addr];
    end
  end

  // Read sees pre-edge contents: no write-to-read bypass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_re_q[k] <= '0;
        mem_im_q[k] <= '0;
      end
      real_q <= '0;
      imag_q <= '0;
    end else begin
      if (en) begin
        mem_re_q[wr_addr] <= re_d;
        mem_im_q[wr_addr] <= im_d;
      end
      real_q <= real_d;
      imag_q <= imag_d;
    end
  end

  assign real_part = real_q;
  assign imag_part = imag_q;

endmodule

// File: tb/tb_nrs_conj_mult_buf.sv
// Directed bench for nrs_conj_mult_buf.
// Hand-computed products, saturation, addressing, enable, reset.
module tb_nrs_conj_mult_buf;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [1:0] wr_addr;
  logic [1:0] rd_addr;
  logic signed [15:0] rx_r;
  logic signed [15:0] rx_i;
  logic nrs_r;
  logic nrs_i;
  logic signed [15:0] real_part;
  logic signed [15:0] imag_part;

  int n_cmp = 0;
  int n_err = 0;

  nrs_conj_mult_buf dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rx_r      (rx_r),
    .rx_i      (rx_i),
    .nrs_r     (nrs_r),
    .nrs_i     (nrs_i),
    .real_part (real_part),
    .imag_part (imag_part)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic signed [15:0] er,
    input logic signed [15:0] ei
  );
    n_cmp++;
    assert (real_part === er) else begin
      n_err++;
      $error("FAIL %s: real_part=%0d expected %0d",
             tag, real_part, er);
    end
    n_cmp++;
    assert (imag_part === ei) else begin
      n_err++;
      $error("FAIL %s: imag_part=%0d expected %0d",
             tag, imag_part, ei);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [1:0] wa,
    input logic signed [15:0] r,
    input logic signed [15:0] i,
    input logic sr,
    input logic si
  );
    wr_addr = wa;
    rx_r    = r;
    rx_i    = i;
    nrs_r   = sr;
    nrs_i   = si;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    rd_addr = 2'd0;
    drive(2'd0, 16'sd0, 16'sd0, 1'b0, 1'b0);

    repeat (30) tick();
    chk("reset_hold", 16'sd0, 16'sd0);

    rst = 1'b1;
    en  = 1'b1;
    tick();
    chk("reset_release", 16'sd0, 16'sd0);

    drive(2'd0, 16'sd2048, 16'sd0, 1'b0, 1'b0);
    rd_addr = 2'd0;
    tick();
    chk("latency_1cyc", 16'sd0, 16'sd0);
    tick();
    chk("basic", 16'sd1448, -16'sd1448);

    drive(2'd0, 16'sd1000, 16'sd1000, 1'b0, 1'b0);
    tick();
    chk("no_bypass", 16'sd1448, -16'sd1448);
    tick();
    chk("cancel", 16'sd1414, 16'sd0);

    drive(2'd1, 16'sd2048, 16'sd0, 1'b1, 1'b0);
    rd_addr = 2'd1;
    tick();
    tick();
    chk("sign_nr", -16'sd1448, -16'sd1448);

    drive(2'd2, 16'sd0, 16'sd2048, 1'b0, 1'b1);
    rd_addr = 2'd2;
    tick();
    tick();
    chk("sign_ni", -16'sd1448, 16'sd1448);

    drive(2'd3, -16'sd1, 16'sd0, 1'b0, 1'b0);
    rd_addr = 2'd3;
    tick();
    tick();
    chk("floor", -16'sd1, 16'sd0);

    drive(2'd0, 16'sd32767, 16'sd32767, 1'b0, 1'b0);
    rd_addr = 2'd0;
    tick();
    tick();
    chk("sat_pos", 16'sd32767, 16'sd0);

    drive(2'd1, 16'sh8000, 16'sh8000, 1'b0, 1'b0);
    rd_addr = 2'd1;
    tick();
    tick();
    chk("sat_neg", 16'sh8000, 16'sd0);

    drive(2'd0, 16'sd2048, 16'sd0, 1'b0, 1'b0);
    tick();
    drive(2'd1, 16'sd1000, 16'sd1000, 1'b0, 1'b0);
    tick();
    drive(2'd2, 16'sd2048, 16'sd0, 1'b1, 1'b0);
    tick();
    drive(2'd3, -16'sd1, 16'sd0, 1'b0, 1'b0);
    tick();
    drive(2'd0, 16'sd2048, 16'sd0, 1'b0, 1'b0);
    rd_addr = 2'd3;
    tick();
    chk("buf_rd3", -16'sd1, 16'sd0);
    rd_addr = 2'd2;
    tick();
    chk("buf_rd2", -16'sd1448, -16'sd1448);
    rd_addr = 2'd1;
    tick();
    chk("buf_rd1", 16'sd1414, 16'sd0);
    rd_addr = 2'd0;
    tick();
    chk("buf_rd0", 16'sd1448, -16'sd1448);

    en = 1'b0;
    drive(2'd1, 16'sd5000, -16'sd7000, 1'b1, 1'b1);
    rd_addr = 2'd1;
    tick();
    chk("en_low", 16'sd0, 16'sd0);
    tick();
    chk("en_low_hold", 16'sd0, 16'sd0);

    en = 1'b1;
    drive(2'd0, 16'sd2048, 16'sd0, 1'b0, 1'b0);
    tick();
    chk("reread1", 16'sd1414, 16'sd0);
    rd_addr = 2'd3;
    tick();
    chk("reread3", -16'sd1, 16'sd0);

    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", 16'sd0, 16'sd0);
    tick();
    rst = 1'b1;
    drive(2'd3, 16'sd0, 16'sd0, 1'b0, 1'b0);
    rd_addr = 2'd1;
    tick();
    chk("rst_clr1", 16'sd0, 16'sd0);
    rd_addr = 2'd0;
    tick();
    chk("rst_clr0", 16'sd0, 16'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
